booth_mul_seq: RTL and testbench

- Sequential signed radix-2 Booth multiplier that sits upstream of the carry look-ahead adder chain.
- It drives one addend and the carry-in of the team's CLA adder (built from 4-bit look-ahead blocks) every cycle, and consumes the sum as the next partial product.
- It produces a 2*WIDTH-bit product after WIDTH iterations, using a start/done/clear handshake.
- It is the multiply unit feeding the ALU result mux.

---
 rtl/booth_mul_seq_if.sv | 22 ++
 rtl/booth_mul_seq.sv | 175 +++++++++++++++++
 tb/tb_booth_mul_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
interface booth_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                 op_start;
  logic                 op_clear;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 op_busy;
  logic                 op_done;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output op_start, op_clear, multiplicand, multiplier,
    input  op_busy, op_done, result
  );

  modport slave (
    input  op_start, op_clear, multiplicand, multiplier,
    output op_busy, op_done, result
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier. One Booth step per clock,
// each step routed through a carry look-ahead adder built from 4-bit blocks.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  booth_mul_seq_if.slave bus
);

  localparam int AW = WIDTH + 4;
  localparam int NB = AW / 4;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CW-1:0]             count;
  logic signed [WIDTH:0]     acc;
  logic [WIDTH-1:0]          q_reg;
  logic                      q_m1;
  logic signed [WIDTH-1:0]   m_reg;
  logic [2*WIDTH-1:0]        result_reg;
  logic                      busy_reg;
  logic                      done_reg;

  logic [AW-1:0]             add_a;
  logic [AW-1:0]             add_b;
  logic [AW-1:0]             add_s;
  logic                      add_cin;
  logic [NB:0]               cy;
  logic [3:0]                sum_hi_unused;

  logic [WIDTH:0]            acc_shift;
  logic [WIDTH-1:0]          q_shift;
  logic                      last_step;

  // 4-bit look-ahead block: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Booth recoding: pick +M, -M (invert plus carry-in) or zero for the adder.
  always_comb begin
    add_a   = {{3{acc[WIDTH]}}, acc};
    add_b   = '0;
    add_cin = 1'b0;
    case ({q_reg[0], q_m1})
      2'b01: add_b = {{4{m_reg[WIDTH-1]}}, m_reg};
      2'b10: begin
        add_b   = ~{{4{m_reg[WIDTH-1]}}, m_reg};
        add_cin = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  assign cy[0] = add_cin;

  for (genvar i = 0; i < NB; i++) begin : g_cla
    logic [4:0] blk;
    assign blk            = cla4(add_a[4*i +: 4], add_b[4*i +: 4], cy[i]);
    assign add_s[4*i +: 4] = blk[3:0];
    assign cy[i+1]        = blk[4];
  end

  // Bits above the guard bit and the final carry-out play no part in the product.
  assign sum_hi_unused = {cy[NB], add_s[AW-1:WIDTH+1]};

  assign acc_shift = {add_s[WIDTH], add_s[WIDTH:1]};
  assign q_shift   = {add_s[0], q_reg[WIDTH-1:1]};
  assign last_step = (count == CW'(WIDTH - 1));

  // Next-state decode; clear wins over start in DONE.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (bus.op_start) state_next = EXEC;
      EXEC: begin
        if (bus.op_clear)    state_next = INIT;
        else if (last_step)  state_next = DONE;
      end
      DONE:    if (bus.op_clear) state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Registered status flags, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= (state_next == EXEC);
      done_reg <= (state_next == DONE);
    end
  end

  // Operand capture, Booth step/shift, and result load on the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg      <= '0;
      acc        <= '0;
      q_reg      <= '0;
      q_m1       <= 1'b0;
      count      <= '0;
      result_reg <= '0;
    end else begin
      case (state)
        INIT: begin
          if (bus.op_start) begin
            m_reg <= bus.multiplicand;
            q_reg <= bus.multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
          end
        end
        EXEC: begin
          if (bus.op_clear) begin
            acc        <= '0;
            q_reg      <= '0;
            q_m1       <= 1'b0;
            count      <= '0;
            result_reg <= '0;
          end else begin
            acc   <= acc_shift;
            q_reg <= q_shift;
            q_m1  <= q_reg[0];
            count <= count + CW'(1);
            if (last_step) result_reg <= {acc_shift[WIDTH-1:0], q_shift};
          end
        end
        DONE: begin
          if (bus.op_clear) begin
            acc        <= '0;
            q_reg      <= '0;
            q_m1       <= 1'b0;
            count      <= '0;
            result_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op_busy = busy_reg;
  assign bus.op_done = done_reg;
  assign bus.result  = result_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: products, handshake corners, aborts.
module tb_booth_mul_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;

  booth_mul_seq_if #(.WIDTH(WIDTH)) bus_i ();

  booth_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] m, input logic [31:0] q);
    bus_i.multiplicand = m;
    bus_i.multiplier   = q;
    bus_i.op_start     = 1'b1;
    tick();
    bus_i.op_start     = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (bus_i.op_done !== 1'b1 && cycles < 100) begin
      if (bus_i.op_busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cycles++;
    end
  endtask

  task automatic clear_op();
    bus_i.op_clear = 1'b1;
    tick();
    bus_i.op_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_i.op_start = 1'b0;
    bus_i.op_clear = 1'b0;
    bus_i.multiplicand = '0;
    bus_i.multiplier   = '0;
    tick();
    tick();
    n_vec++; if (bus_i.op_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus_i.op_busy); end
    n_vec++; if (bus_i.op_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus_i.op_done); end
    n_vec++; if (bus_i.result !== 64'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus_i.result); end
    reset = 1'b0;
    tick();
    n_vec++; if (bus_i.op_busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus_i.op_busy); end
  endtask

  task automatic test_basic();
    int c; bit ok;
    start_op(32'd5, 32'd3);
    wait_done(c, ok);
    n_vec++; if (c !== 32) begin n_bad++; $display("FAIL basic_latency: got %0d want 32", c); end
    n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", ok); end
    n_vec++; if (bus_i.op_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_in_done: got %b want 0", bus_i.op_busy); end
    n_vec++; if (bus_i.result !== 64'h0000_0000_0000_000F) begin n_bad++; $display("FAIL basic_result: got %h want 000000000000000f", bus_i.result); end
    tick();
    n_vec++; if (bus_i.result !== 64'h0000_0000_0000_000F) begin n_bad++; $display("FAIL basic_hold: got %h want 000000000000000f", bus_i.result); end
    clear_op();
    n_vec++; if (bus_i.op_done !== 1'b0) begin n_bad++; $display("FAIL basic_clear_done: got %b want 0", bus_i.op_done); end
    n_vec++; if (bus_i.result !== 64'h0) begin n_bad++; $display("FAIL basic_clear_result: got %h want 0", bus_i.result); end
  endtask

  task automatic test_negative();
    int c; bit ok;
    start_op(32'hFFFF_FFF9, 32'd6);
    wait_done(c, ok);
    n_vec++; if (bus_i.result !== 64'hFFFF_FFFF_FFFF_FFD6) begin n_bad++; $display("FAIL neg_result: got %h want ffffffffffffffd6", bus_i.result); end
    clear_op();
  endtask

  task automatic test_corners();
    logic [31:0] tm [3];
    logic [31:0] tq [3];
    logic [63:0] tp [3];
    int c; bit ok;
    tm[0] = 32'h8000_0000; tq[0] = 32'h8000_0000; tp[0] = 64'h4000_0000_0000_0000;
    tm[1] = 32'hFFFF_FFFF; tq[1] = 32'hFFFF_FFFF; tp[1] = 64'h0000_0000_0000_0001;
    tm[2] = 32'h7FFF_FFFF; tq[2] = 32'h8000_0000; tp[2] = 64'hC000_0000_8000_0000;
    for (int i = 0; i < 3; i++) begin
      start_op(tm[i], tq[i]);
      wait_done(c, ok);
      n_vec++; if (bus_i.result !== tp[i]) begin n_bad++; $display("FAIL corner%0d_result: got %h want %h", i, bus_i.result, tp[i]); end
      clear_op();
    end
  endtask

  task automatic test_start_in_exec();
    int c; bit ok;
    start_op(32'd11, 32'd13);
    repeat (5) tick();
    bus_i.multiplicand = 32'd100;
    bus_i.multiplier   = 32'd100;
    bus_i.op_start     = 1'b1;
    tick();
    bus_i.op_start     = 1'b0;
    wait_done(c, ok);
    n_vec++; if (c + 6 !== 32) begin n_bad++; $display("FAIL exec_start_latency: got %0d want 32", c + 6); end
    n_vec++; if (bus_i.result !== 64'h0000_0000_0000_008F) begin n_bad++; $display("FAIL exec_start_result: got %h want 000000000000008f", bus_i.result); end
    clear_op();
  endtask

  task automatic test_start_clear_in_done();
    int c; bit ok;
    start_op(32'd4, 32'd4);
    wait_done(c, ok);
    n_vec++; if (bus_i.result !== 64'h10) begin n_bad++; $display("FAIL sc_result: got %h want 10", bus_i.result); end
    bus_i.op_start = 1'b1;
    bus_i.op_clear = 1'b1;
    tick();
    bus_i.op_start = 1'b0;
    bus_i.op_clear = 1'b0;
    n_vec++; if (bus_i.op_done !== 1'b0) begin n_bad++; $display("FAIL sc_done: got %b want 0", bus_i.op_done); end
    n_vec++; if (bus_i.op_busy !== 1'b0) begin n_bad++; $display("FAIL sc_busy: got %b want 0", bus_i.op_busy); end
    n_vec++; if (bus_i.result !== 64'h0) begin n_bad++; $display("FAIL sc_clear_result: got %h want 0", bus_i.result); end
    repeat (3) tick();
    n_vec++; if (bus_i.op_busy !== 1'b0) begin n_bad++; $display("FAIL sc_no_restart: got %b want 0", bus_i.op_busy); end
  endtask

  task automatic test_clear_in_exec();
    bit seen_done;
    start_op(32'd9, 32'd9);
    repeat (10) tick();
    n_vec++; if (bus_i.op_busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", bus_i.op_busy); end
    clear_op();
    n_vec++; if (bus_i.op_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus_i.op_busy); end
    n_vec++; if (bus_i.result !== 64'h0) begin n_bad++; $display("FAIL abort_result: got %h want 0", bus_i.result); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_i.op_done === 1'b1 || bus_i.op_busy === 1'b1) seen_done = 1'b1;
      tick();
    end
    n_vec++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL abort_stays_idle: got %b want 0", seen_done); end
  endtask

  task automatic test_async_reset();
    int c; bit ok;
    start_op(32'd21, 32'd21);
    repeat (20) tick();
    n_vec++; if (bus_i.op_busy !== 1'b1) begin n_bad++; $display("FAIL areset_busy_before: got %b want 1", bus_i.op_busy); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus_i.op_busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b want 0", bus_i.op_busy); end
    n_vec++; if (bus_i.op_done !== 1'b0) begin n_bad++; $display("FAIL areset_done: got %b want 0", bus_i.op_done); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    start_op(32'd2, 32'hFFFF_FFFD);
    wait_done(c, ok);
    n_vec++; if (c !== 32) begin n_bad++; $display("FAIL after_reset_latency: got %0d want 32", c); end
    n_vec++; if (bus_i.result !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_bad++; $display("FAIL after_reset_result: got %h want fffffffffffffffa", bus_i.result); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (bus_i.result !== 64'h0) begin n_bad++; $display("FAIL areset_done_result: got %h want 0", bus_i.result); end
    n_vec++; if (bus_i.op_done !== 1'b0) begin n_bad++; $display("FAIL areset_done_flag: got %b want 0", bus_i.op_done); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_corners();
    test_start_in_exec();
    test_start_clear_in_done();
    test_clear_in_exec();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
